// File: rtl/bananachine_pkg.sv
// Shared constants for the CPU memory-port I/O window: decode mask,
// register offsets and TXSTAT field positions.
package bananachine_pkg;

    // I/O window base address; a hit means addr[WIDTH-1:4] is all ones
    localparam logic [15:0] IO_BASE = 16'hFFF0;
    localparam int unsigned OFF_W   = 4;

    // Register offsets within the window (addr[3:0])
    localparam logic [OFF_W-1:0] OFF_SW     = 4'd0;
    localparam logic [OFF_W-1:0] OFF_LED    = 4'd1;
    localparam logic [OFF_W-1:0] OFF_TIMER  = 4'd2;
    localparam logic [OFF_W-1:0] OFF_TXDATA = 4'd3;
    localparam logic [OFF_W-1:0] OFF_TXSTAT = 4'd4;
    localparam logic [OFF_W-1:0] OFF_CMP    = 4'd5;

    // TXSTAT bit positions
    localparam int unsigned TXSTAT_FULL    = 0;
    localparam int unsigned TXSTAT_EMPTY   = 1;
    localparam int unsigned TXSTAT_OVF     = 2;
    localparam int unsigned TXSTAT_CNT_LSB = 8;
    localparam int unsigned TXSTAT_CNT_W   = 8;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO used as the TX byte queue.
// Ports: clk, reset (sync active-low), push_i/din_i write side,
//        pop_i read side, full_o/empty_o/count_o registered status,
//        head_c_o combinational view of the head entry.
// Pushes while full and pops while empty are ignored.
module io_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [WIDTH-1:0]           head_c_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // Pointer/count update; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        do_push  = push_i & ~full_q;
        do_pop   = pop_i & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        full_d   = (count_d == CNT_W'(DEPTH));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            if (do_push) mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign full_o   = full_q;
    assign empty_o  = empty_q;
    assign count_o  = count_q;
    assign head_c_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/mmio_responder.sv
// Responder for the CPU load/store port I/O window 0xFFF0-0xFFFF.
// Serves switches, LEDs, a prescaled timer and a TX byte FIFO; load data
// appears one cycle after re, matching RAM port-b timing.
// Ports: clk, reset (sync active-low), addr/wdata/we/re CPU port,
//        io_hit (combinational decode), io_sel/io_rdata (registered load),
//        switches in, leds out, tx_data/tx_valid/tx_ready FIFO drain,
//        irq timer-compare interrupt.
// Build option: define MMIO_TIMER_IRQ_EN to add the CMP register (offset 5)
// and the sticky irq; otherwise irq is tied low and offset 5 reads 0.
module mmio_responder
    import bananachine_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned PRESCALE   = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             we,
    input  logic             re,
    output logic             io_hit,
    output logic             io_sel,
    output logic [WIDTH-1:0] io_rdata,
    input  logic [WIDTH-1:0] switches,
    output logic [WIDTH-1:0] leds,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             irq
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [OFF_W-1:0] off;
    logic             wr_en, rd_en;

    logic [WIDTH-1:0] sw_meta_q, sw_sync_q;
    logic [WIDTH-1:0] leds_q, leds_d;
    logic [WIDTH-1:0] timer_q, timer_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic             ovf_q, ovf_d;
    logic             io_sel_q;
    logic [WIDTH-1:0] io_rdata_q, io_rdata_d;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] txstat;
    logic [WIDTH-1:0] cmp_rdata;

    logic             fifo_push, fifo_pop;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]       fifo_head;

    // Address decode
    assign off    = addr[OFF_W-1:0];
    assign io_hit = &addr[WIDTH-1:OFF_W];
    assign wr_en  = we & io_hit;
    assign rd_en  = re & io_hit;

    assign fifo_push = wr_en && (off == OFF_TXDATA);
    assign fifo_pop  = ~fifo_empty & tx_ready;

    io_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_i   (fifo_push),
        .din_i    (wdata[7:0]),
        .pop_i    (fifo_pop),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count),
        .head_c_o (fifo_head)
    );

    // Status word for TXSTAT reads
    always_comb begin
        txstat = '0;
        txstat[TXSTAT_FULL]  = fifo_full;
        txstat[TXSTAT_EMPTY] = fifo_empty;
        txstat[TXSTAT_OVF]   = ovf_q;
        txstat[TXSTAT_CNT_LSB +: TXSTAT_CNT_W] = TXSTAT_CNT_W'(fifo_count);
    end

    // Next state for registers, timer, overflow flag and read mux
    always_comb begin
        leds_d     = leds_q;
        timer_d    = timer_q;
        presc_d    = presc_q;
        ovf_d      = ovf_q;
        rdata      = '0;

        if (presc_q == PRE_MAX) begin
            presc_d = '0;
            timer_d = timer_q + WIDTH'(1);
        end else begin
            presc_d = presc_q + PRE_W'(1);
        end

        if (wr_en && (off == OFF_LED)) leds_d = wdata;
        // A timer load overrides a same-cycle tick
        if (wr_en && (off == OFF_TIMER)) begin
            timer_d = wdata;
            presc_d = '0;
        end

        // Status read clears overflow; a fresh dropped push re-sets it
        if (rd_en && (off == OFF_TXSTAT)) ovf_d = 1'b0;
        if (fifo_push && fifo_full)       ovf_d = 1'b1;

        unique case (off)
            OFF_SW:     rdata = sw_sync_q;
            OFF_LED:    rdata = leds_q;
            OFF_TIMER:  rdata = timer_q;
            OFF_TXSTAT: rdata = txstat;
            OFF_CMP:    rdata = cmp_rdata;
            default:    rdata = '0;
        endcase

        io_rdata_d = rd_en ? rdata : io_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            leds_q     <= '0;
            timer_q    <= '0;
            presc_q    <= '0;
            ovf_q      <= 1'b0;
            io_sel_q   <= 1'b0;
            io_rdata_q <= '0;
        end else begin
            sw_meta_q  <= switches;
            sw_sync_q  <= sw_meta_q;
            leds_q     <= leds_d;
            timer_q    <= timer_d;
            presc_q    <= presc_d;
            ovf_q      <= ovf_d;
            io_sel_q   <= rd_en;
            io_rdata_q <= io_rdata_d;
        end
    end

`ifdef MMIO_TIMER_IRQ_EN
    logic [WIDTH-1:0] cmp_q, cmp_d;
    logic             irq_q, irq_d;

    // Sticky compare interrupt; a CMP write clears it and wins over a set
    always_comb begin
        cmp_d = cmp_q;
        irq_d = irq_q;
        if (timer_q == cmp_q) irq_d = 1'b1;
        if (wr_en && (off == OFF_CMP)) begin
            cmp_d = wdata;
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cmp_q <= '1;
            irq_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
            irq_q <= irq_d;
        end
    end

    assign cmp_rdata = cmp_q;
    assign irq       = irq_q;
`else
    assign cmp_rdata = '0;
    assign irq       = 1'b0;
`endif

    assign io_sel   = io_sel_q;
    assign io_rdata = io_rdata_q;
    assign leds     = leds_q;
    assign tx_data  = fifo_head;
    assign tx_valid = ~fifo_empty;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder (PRESCALE=4, FIFO_DEPTH=8).
module tb_mmio_responder;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic        re;
    logic        io_hit;
    logic        io_sel;
    logic [15:0] io_rdata;
    logic [15:0] switches;
    logic [15:0] leds;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    int total;
    int bad;

    mmio_responder #(
        .WIDTH      (16),
        .FIFO_DEPTH (8),
        .PRESCALE   (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .re       (re),
        .io_hit   (io_hit),
        .io_sel   (io_sel),
        .io_rdata (io_rdata),
        .switches (switches),
        .leds     (leds),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
        addr  = 16'h0000;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] q, output logic sel);
        addr = a;
        re   = 1'b1;
        @(posedge clk);
        #1;
        re   = 1'b0;
        addr = 16'h0000;
        q    = io_rdata;
        sel  = io_sel;
    endtask

    logic [15:0] q;
    logic        sel;

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        addr     = 16'h0000;
        wdata    = 16'h0000;
        we       = 1'b0;
        re       = 1'b0;
        switches = 16'h0000;
        tx_ready = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_leds",     32'(leds),     32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_io_sel",   32'(io_sel),   32'h0);
        check("rst_io_rdata", 32'(io_rdata), 32'h0);
        check("rst_irq",      32'(irq),      32'h0);
        reset = 1'b1;
        rd(16'hFFF4, q, sel);
        check("rst_txstat",     32'(q),   32'h0002);
        check("rst_txstat_sel", 32'(sel), 32'h1);

        // LEDs and switches
        wr(16'hFFF1, 16'hA5A5);
        check("led_write", 32'(leds), 32'hA5A5);
        switches = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        rd(16'hFFF0, q, sel);
        check("sw_read",     32'(q),   32'h1234);
        check("sw_read_sel", 32'(sel), 32'h1);
        // io_rdata holds with re low; io_sel drops
        @(posedge clk);
        #1;
        check("rdata_hold", 32'(io_rdata), 32'h1234);
        check("sel_drop",   32'(io_sel),   32'h0);
        // SW is read-only
        wr(16'hFFF0, 16'hFFFF);
        rd(16'hFFF0, q, sel);
        check("sw_ro", 32'(q), 32'h1234);
        // Same-cycle store and load return the old value
        addr = 16'hFFF1; wdata = 16'h5A5A; we = 1'b1; re = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0; re = 1'b0;
        check("wr_rd_old", 32'(io_rdata), 32'hA5A5);
        check("wr_rd_new", 32'(leds),     32'h5A5A);
        // Unmapped offset reads 0
        rd(16'hFFF9, q, sel);
        check("unmapped", 32'(q), 32'h0);
        // Non-IO address: no hit, no select, no LED write
        addr = 16'h0100; wdata = 16'hFFFF; we = 1'b1; re = 1'b1;
        #1;
        check("nonio_hit", 32'(io_hit), 32'h0);
        @(posedge clk);
        #1;
        we = 1'b0; re = 1'b0;
        check("nonio_sel",  32'(io_sel), 32'h0);
        check("nonio_leds", 32'(leds),   32'h5A5A);

        // Timer wrap and count with PRESCALE=4
        wr(16'hFFF2, 16'hFFFF);
        repeat (4) @(posedge clk);
        #1;
        rd(16'hFFF2, q, sel);
        check("timer_wrap", 32'(q), 32'h0000);
        repeat (8) @(posedge clk);
        #1;
        rd(16'hFFF2, q, sel);
        check("timer_count", 32'(q), 32'h0002);

        // FIFO fill with overflow
        for (int i = 1; i <= 9; i++) wr(16'hFFF3, 16'(i));
        rd(16'hFFF4, q, sel);
        check("fifo_full_stat", 32'(q), 32'h0805);
        rd(16'hFFF4, q, sel);
        check("fifo_ovf_clr", 32'(q), 32'h0801);
        rd(16'hFFF3, q, sel);
        check("txdata_read0", 32'(q), 32'h0);
        rd(16'hFFF4, q, sel);
        check("txdata_nopop", 32'(q), 32'h0801);
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_valid", 32'(tx_valid), 32'h1);
            check("drain_data",  32'(tx_data),  32'(i));
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // Simultaneous push/pop at count 3
        wr(16'hFFF3, 16'h0011);
        wr(16'hFFF3, 16'h0012);
        wr(16'hFFF3, 16'h0013);
        tx_ready = 1'b1;
        wr(16'hFFF3, 16'h0014);
        tx_ready = 1'b0;
        rd(16'hFFF4, q, sel);
        check("pushpop_cnt", 32'(q), 32'h0300);
        check("pushpop_head", 32'(tx_data), 32'h12);
        // Fill, then push while full with a same-cycle pop
        for (int i = 5; i <= 9; i++) wr(16'hFFF3, 16'(16'h0010 + i));
        tx_ready = 1'b1;
        wr(16'hFFF3, 16'h0077);
        tx_ready = 1'b0;
        rd(16'hFFF4, q, sel);
        check("full_drop_ovf", 32'(q), 32'h0704);
        tx_ready = 1'b1;
        for (int i = 3; i <= 9; i++) begin
            check("drain2_data", 32'(tx_data), 32'(8'h10 + i));
            @(posedge clk);
            #1;
        end
        check("drain2_empty", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

`ifdef MMIO_TIMER_IRQ_EN
        // Compare interrupt
        wr(16'hFFF2, 16'h0000);
        wr(16'hFFF5, 16'h0005);
        check("irq_clr_cmp", 32'(irq), 32'h0);
        repeat (19) @(posedge clk);
        #1;
        check("irq_before", 32'(irq), 32'h0);
        @(posedge clk);
        #1;
        check("irq_set", 32'(irq), 32'h1);
        @(posedge clk);
        #1;
        check("irq_sticky", 32'(irq), 32'h1);
        wr(16'hFFF5, 16'h0100);
        check("irq_cmp_wr_clr", 32'(irq), 32'h0);
        rd(16'hFFF5, q, sel);
        check("cmp_read", 32'(q), 32'h0100);
`else
        // Without the compare option offset 5 is inert and irq stays low
        wr(16'hFFF5, 16'h1234);
        rd(16'hFFF5, q, sel);
        check("cmp_absent", 32'(q), 32'h0);
        check("irq_tied", 32'(irq), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
